// File: rtl/spi_host_master.sv
// spi_host_master
//   Mode-0 SPI host for the SmolBoi slave. It turns one parallel request
//   ({addr, rw, wdata}) into a single 16-bit frame, sent MSB first as
//   addr[6:0], rw, data[7:0]. On reads it returns the byte seen on miso
//   during the data phase.
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-high reset
//   start  in   request strobe, accepted only while busy == 0
//   rw     in   1 = read, 0 = write (sampled with start)
//   addr   in   7-bit slave address (sampled with start)
//   wdata  in   data-phase byte (still shifted out on reads)
//   busy   out  high while a frame is in progress
//   done   out  one-cycle pulse at frame end
//   rdata  out  last read byte; holds until the next read completes
//   cs     out  chip select, active low
//   sclk   out  SPI clock, idles low
//   mosi   out  host-out data
//   miso   in   host-in data
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | cs high, waiting for start
// SETUP   | cs low, sclk low, CS_SETUP cycles before the first bit
// SHIFT   | 16 bit periods of CLKDIV low + CLKDIV high clk cycles
// HOLD    | cs still low for CS_HOLD cycles after the last fall

module spi_host_master #(
  parameter int CLKDIV   = 16,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam int CW = 16;
  localparam logic [CW-1:0] SETUP_LD = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HALF_LD  = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(CS_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [3:0]      bit_cnt;
  // Frame bits still to be sent; the current bit already sits on mosi.
  logic [14:0]     tx;
  logic [7:0]      rx;
  logic            rw_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      tx      <= '0;
      rx      <= '0;
      rw_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      cs      <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          cs   <= 1'b1;
          sclk <= 1'b0;
          mosi <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            tx      <= {addr[5:0], rw, wdata};
            rw_q    <= rw;
            mosi    <= addr[6];
            cs      <= 1'b0;
            busy    <= 1'b1;
            cnt     <= SETUP_LD;
            bit_cnt <= '0;
            state   <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (cnt == '0) begin
            cnt   <= HALF_LD;
            state <= ST_SHIFT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt <= HALF_LD;
            if (!sclk) begin
              sclk <= 1'b1;
              // All 16 rising-edge samples pass through; only the last
              // eight (data phase) remain when the frame ends.
              rx   <= {rx[6:0], miso};
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == 4'd15) begin
                mosi  <= 1'b0;
                cnt   <= HOLD_LD;
                state <= ST_HOLD;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                mosi    <= tx[14];
                tx      <= {tx[13:0], 1'b0};
              end
            end
          end
        end

        ST_HOLD: begin
          if (cnt == '0) begin
            cs    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (rw_q) rdata <= rx;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_host_master.sv
module tb_spi_host_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // DUT A: default timing, fixed-byte slave model
  logic       start, rw, busy, done, cs, sclk, mosi, miso;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;

  // DUT B: fast timing, memory slave model
  logic       start_b, rw_b, busy_b, done_b, cs_b, sclk_b, mosi_b, miso_b;
  logic [6:0] addr_b;
  logic [7:0] wdata_b, rdata_b;

  spi_host_master dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .cs(cs),
    .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  spi_host_master #(.CLKDIV(8), .CS_SETUP(1), .CS_HOLD(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .rw(rw_b), .addr(addr_b),
    .wdata(wdata_b), .busy(busy_b), .done(done_b), .rdata(rdata_b), .cs(cs_b),
    .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  rdata;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Slave A: drives 1s during the address phase (must be ignored) and
  // slave_byte MSB first during the data phase, changing on sclk falls.
  logic [7:0] slave_byte = 8'h00;
  int sa_idx = 0;
  always @(negedge cs) begin
    sa_idx = 0;
    miso   = 1'b1;
  end
  always @(negedge sclk) begin
    if (!cs) begin
      sa_idx++;
      if (sa_idx >= 8 && sa_idx < 16) miso = slave_byte[15-sa_idx];
      else miso = 1'b1;
    end
  end

  // Slave B: small behavioural memory slave.
  logic [7:0]  mem_b [128];
  logic [15:0] sb_sh = '0;
  logic [6:0]  sb_addr = '0;
  logic        sb_rw = 1'b0;
  int          sb_cnt = 0;
  always @(negedge cs_b) sb_cnt = 0;
  always @(posedge sclk_b) begin
    if (!cs_b) begin
      sb_sh = {sb_sh[14:0], mosi_b};
      sb_cnt++;
      if (sb_cnt == 8) begin
        sb_addr = sb_sh[7:1];
        sb_rw   = sb_sh[0];
      end
      if (sb_cnt == 16 && !sb_rw) mem_b[sb_addr] = sb_sh[7:0];
    end
  end
  always @(negedge sclk_b) begin
    if (!cs_b && sb_rw && sb_cnt >= 8 && sb_cnt < 16) miso_b = mem_b[sb_addr][15-sb_cnt];
  end

  // Monitor A
  logic        cs_q = 1'b1, sclk_q = 1'b0;
  logic [15:0] cap = '0;
  int          pulses = 0, cyc = 0;
  always @(negedge clk) begin
    if (cs_q && !cs) begin
      cap = '0; pulses = 0; cyc = 0;
    end
    if (!cs) cyc++;
    if (!sclk_q && sclk) begin
      cap = {cap[14:0], mosi};
      pulses++;
    end
    if (done) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_done: got done=1 expected no frame end");
      end else begin
        ea = qa.pop_front();
        chk("a_frame", 32'(cap), 32'(ea.frame));
        chk("a_pulses", pulses, 16);
        chk("a_rdata", 32'(rdata), 32'(ea.rdata));
        chk("a_cs_low_cycles", cyc, ea.cyc);
        chk("a_busy_in_done", 32'(busy), 0);
      end
    end
    cs_q = cs; sclk_q = sclk;
  end

  // Monitor B
  logic cs_bq = 1'b1;
  int   cyc_b = 0;
  always @(negedge clk) begin
    if (cs_bq && !cs_b) cyc_b = 0;
    if (!cs_b) cyc_b++;
    if (done_b) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_done: got done=1 expected no frame end");
      end else begin
        eb = qb.pop_front();
        chk("b_rdata", 32'(rdata_b), 32'(eb.rdata));
        chk("b_cs_low_cycles", cyc_b, eb.cyc);
      end
    end
    cs_bq = cs_b;
  end

  logic [7:0] model_rd = 8'h00;
  logic [7:0] model_rd_b = 8'h00;

  task automatic issue_a(input logic r, input logic [6:0] a, input logic [7:0] d, input bit track);
    exp_t e;
    @(negedge clk);
    rw = r; addr = a; wdata = d; start = 1'b1;
    if (r) model_rd = slave_byte;
    e.frame = {a, r, d}; e.rdata = model_rd; e.cyc = 520;
    if (track) qa.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done_a();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 3000);
    if (!done) begin
      checks++; errors++;
      $display("FAIL a_timeout: got no done expected done within 3000 cycles");
    end
  endtask

  task automatic issue_b(input logic r, input logic [6:0] a, input logic [7:0] d, input logic [7:0] rd);
    exp_t e;
    @(negedge clk);
    rw_b = r; addr_b = a; wdata_b = d; start_b = 1'b1;
    e.frame = {a, r, d}; e.rdata = rd; e.cyc = 258;
    qb.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic wait_done_b();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_b && n < 2000);
    if (!done_b) begin
      checks++; errors++;
      $display("FAIL b_timeout: got no done expected done within 2000 cycles");
    end
  endtask

  initial begin
    start = 0; rw = 0; addr = '0; wdata = '0; miso = 0;
    start_b = 0; rw_b = 0; addr_b = '0; wdata_b = '0; miso_b = 0;
    for (int i = 0; i < 128; i++) mem_b[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs), 1);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_cs_b", 32'(cs_b), 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Write 0x05 <= 0xA5: frame 0x0AA5, rdata stays 0
    issue_a(1'b0, 7'h05, 8'hA5, 1'b1);
    wait_done_a();

    // Read 0x05 with slave returning 0x3C
    slave_byte = 8'h3C;
    issue_a(1'b1, 7'h05, 8'h00, 1'b1);
    wait_done_a();

    // start during an active frame is ignored
    issue_a(1'b0, 7'h12, 8'h5A, 1'b1);
    repeat (98) @(negedge clk);
    rw = 1'b1; addr = 7'h7F; wdata = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ignored_start_busy", 32'(busy), 1);
    wait_done_a();
    repeat (40) @(negedge clk);

    // Reset mid-frame while sclk is high
    slave_byte = 8'h99;
    issue_a(1'b1, 7'h33, 8'h00, 1'b0);
    repeat (213) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_cs", 32'(cs), 1);
    chk("midrst_sclk", 32'(sclk), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_rdata", 32'(rdata), 0);
    model_rd = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Clean frame after reset
    slave_byte = 8'hC3;
    issue_a(1'b1, 7'h40, 8'h00, 1'b1);
    wait_done_a();

    // start held high through done: back-to-back frames
    begin
      exp_t e;
      @(negedge clk);
      rw = 1'b0; addr = 7'h01; wdata = 8'h55; start = 1'b1;
      e.frame = 16'h0255; e.rdata = model_rd; e.cyc = 520;
      qa.push_back(e);
      qa.push_back(e);
      wait_done_a();
      chk("b2b_cs_high_in_done", 32'(cs), 1);
      @(negedge clk);
      chk("b2b_cs_low_next", 32'(cs), 0);
      chk("b2b_busy_next", 32'(busy), 1);
      start = 1'b0;
      wait_done_a();
    end

    // Fast-timing instance against memory slave
    issue_b(1'b0, 7'h12, 8'h34, 8'h00);
    wait_done_b();
    issue_b(1'b1, 7'h12, 8'h00, 8'h34);
    wait_done_b();

    repeat (20) @(negedge clk);
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
